sync_serial_codec: RTL and testbench
====================================

SYNC_SERIAL_CODEC -- requirements
Module: sync_serial_codec

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, setting the payload bits per frame (range 4..32).
REQ-002 The block SHALL have parameter CLK_DIV, default 50, setting the txck half-period in clk cycles; bit period is 2*CLK_DIV (range 2..4096).
REQ-003 The block SHALL have parameter PARITY_EN, default 1: 1 inserts an even-parity bit, 0 omits it.
REQ-004 The block SHALL have port clk  in  1  sole clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port loopback_en  in  1  1 routes internal txsd/txck to the receiver instead of rxsd/rxck.
REQ-007 The block SHALL have ports tx_data  in  DATA_W, tx_valid  in  1, and tx_ready  out  1: the transmit word handshake.
REQ-008 The block SHALL have ports rx_data  out  DATA_W, rx_valid  out  1, and rx_ready  in  1: the receive word handshake.
REQ-009 The block SHALL have ports rx_perr, rx_ferr, rx_ovr  out  1 each: parity error, framing error, and sticky overrun.
REQ-010 The block SHALL have ports txsd  out  1, txck  out  1, tx_busy  out  1: serial data, forwarded clock, and frame in progress.
REQ-011 The block SHALL have ports rxsd  in  1 and rxck  in  1: asynchronous serial data and clock inputs.

Function
REQ-012 A frame SHALL be start(0), DATA_W data bits MSB first, parity if PARITY_EN, then stop(1); length NB = DATA_W+PARITY_EN+2.
REQ-013 The TX FSM SHALL have states T_IDLE, T_START, T_DATA, T_PAR, T_STOP; T_PAR is skipped when PARITY_EN=0.
REQ-014 tx_ready SHALL be 1 only in T_IDLE; tx_valid&&tx_ready latches tx_data, and txsd drives start on the next cycle.
REQ-015 For each bit, txck SHALL be low for CLK_DIV cycles then high for CLK_DIV cycles; txsd changes only on the txck falling edge.
REQ-016 txsd and txck SHALL idle high; the frame takes exactly NB*2*CLK_DIV cycles, then T_IDLE; tx_busy=1 outside T_IDLE.
REQ-017 With tx_valid held high, tx_ready SHALL be high for exactly 1 cycle between consecutive frames.
REQ-018 The parity bit SHALL equal the XOR of the data bits (even parity).
REQ-019 The selected rxsd/rxck pair SHALL pass through a 2-flop synchroniser; the receiver acts only on detected rising edges of the synchronised rxck.
REQ-020 The RX FSM SHALL have states R_IDLE, R_DATA, R_PAR, R_STOP; an rxck edge with sd=0 in R_IDLE starts a frame, and sd=1 in R_IDLE is ignored.
REQ-021 On the stop-bit edge, the receiver SHALL load rx_data, set rx_valid=1, set rx_perr on parity mismatch, and set rx_ferr if stop=0, all in the same cycle.
REQ-022 rx_valid and its error flags SHALL hold until rx_valid&&rx_ready, then clear the next cycle.
REQ-023 If a frame completes while rx_valid=1 without a same-cycle handshake, the new frame SHALL be discarded, rx_data kept, and rx_ovr set.
REQ-024 rx_ovr SHALL clear on the next handshake; a handshake in the same cycle as a frame completion SHALL load the new frame with no overrun.
REQ-025 loopback_en SHALL be applied only while the RX FSM is in R_IDLE; mid-frame changes SHALL take effect after the frame.
REQ-026 In loopback, txsd/txck SHALL still drive the pins, and rxsd/rxck SHALL be ignored.

Reset
REQ-027 While rst_n=0 at a clk edge, the block SHALL set: txsd=1, txck=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, rx_ovr=0, both FSMs idle, and synchronisers to 1.
REQ-028 Reset mid-frame SHALL abort both FSMs with no partial word delivered.

Structure
REQ-029 Package sync_serial_pkg SHALL hold the TX/RX state enums and a frame-length function NB(DATA_W, PARITY_EN).
REQ-030 The receive path (synchroniser, edge detect, RX FSM) SHALL be sub-module sync_serial_rx.

Verification (DATA_W=8, CLK_DIV=4, PARITY_EN=1, NB=11)
REQ-031 loopback_en=1, send 0xA5 -> rx_data=0xA5, rx_valid=1, perr=0, ferr=0; tx_busy high for 88 cycles.
REQ-032 External rxsd frame 0x3C with parity bit 1 -> rx_data=0x3C, rx_perr=1, rx_ferr=0.
REQ-033 External frame 0x81 with stop=0 -> rx_ferr=1, rx_data=0x81.
REQ-034 rx_ready=0, loopback 0x11 then 0x22 -> rx_data=0x11, rx_ovr=1; rx_ready=1 for 1 cycle -> rx_valid=0, rx_ovr=0.
REQ-035 rst_n=0 during data bit 4 of a frame -> next cycle txsd=1, txck=1, tx_ready=1, rx_valid=0; a following 0x5A loops back intact.
REQ-036 tx_valid held high with 0x01, 0x02, 0x03 -> three frames, tx_ready high exactly 1 cycle between frames, all three received in order.

Source files
------------

// File: rtl/sync_serial_pkg.sv
// rtl/sync_serial_pkg.sv - shared state encodings and frame-length helper for the sync serial codec
package sync_serial_pkg;

  typedef enum logic [2:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_PAR,
    T_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DATA,
    R_PAR,
    R_STOP
  } rx_state_t;

  // Bits per frame: start + payload + optional parity + stop.
  function automatic int frame_nb(input int data_w, input int parity_en);
    return data_w + parity_en + 2;
  endfunction

endpackage

// File: rtl/sync_serial_rx.sv
// rtl/sync_serial_rx.sv - input select, 2-flop synchroniser, rxck edge detect and receive FSM
module sync_serial_rx
  import sync_serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              loopback_en,
  input  logic              txsd,
  input  logic              txck,
  input  logic              rxsd,
  input  logic              rxck,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              rx_ovr
);

  localparam int IDX_W = $clog2(DATA_W);

  rx_state_t         state, state_next;
  logic              sel;
  logic [1:0]        sd_s, ck_s;
  logic              ck_d;
  logic              rise, sd, done, hs;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;

  assign rise = ck_s[1] & ~ck_d;
  assign sd   = sd_s[1];
  assign done = (state == R_STOP) && rise;
  assign hs   = rx_valid && rx_ready;

  // The source select only follows loopback_en between frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel  <= 1'b0;
      sd_s <= 2'b11;
      ck_s <= 2'b11;
      ck_d <= 1'b1;
    end else begin
      if (state == R_IDLE) sel <= loopback_en;
      sd_s <= {sd_s[0], sel ? txsd : rxsd};
      ck_s <= {ck_s[0], sel ? txck : rxck};
      ck_d <= ck_s[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= R_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      R_IDLE: if (rise && !sd) state_next = R_DATA;
      R_DATA: if (rise && cnt == '0) state_next = (PARITY_EN != 0) ? R_PAR : R_STOP;
      R_PAR:  if (rise) state_next = R_STOP;
      R_STOP: if (rise) state_next = R_IDLE;
      default: state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (rise) begin
      if (state == R_IDLE) cnt <= IDX_W'(DATA_W - 1);
      if (state == R_DATA) begin
        shreg <= {shreg[DATA_W-2:0], sd};
        cnt   <= cnt - 1'b1;
      end
      if (state == R_PAR) par_bit <= sd;
    end
  end

  // A completion coinciding with a handshake replaces the word cleanly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_ovr   <= 1'b0;
    end else if (done && (!rx_valid || hs)) begin
      rx_data  <= shreg;
      rx_valid <= 1'b1;
      rx_perr  <= (PARITY_EN != 0) && (par_bit != ^shreg);
      rx_ferr  <= ~sd;
      rx_ovr   <= 1'b0;
    end else if (done) begin
      rx_ovr <= 1'b1;
    end else if (hs) begin
      rx_valid <= 1'b0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_ovr   <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_serial_codec.sv
// rtl/sync_serial_codec.sv - synchronous serial codec top: transmit FSM with forwarded clock plus receiver
module sync_serial_codec
  import sync_serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 50,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              loopback_en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              rx_ovr,
  output logic              txsd,
  output logic              txck,
  output logic              tx_busy,
  input  logic              rxsd,
  input  logic              rxck
);

  localparam int BIT_T = 2 * CLK_DIV;
  localparam int DIV_W = $clog2(BIT_T);
  localparam int IDX_W = $clog2(DATA_W);

  tx_state_t         tx_state, tx_next;
  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] tx_shreg;
  logic              tx_par, bit_end, load;

  assign bit_end  = (div_cnt == DIV_W'(BIT_T - 1));
  assign tx_ready = (tx_state == T_IDLE);
  assign tx_busy  = (tx_state != T_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) tx_state <= T_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    load    = 1'b0;
    unique case (tx_state)
      T_IDLE: if (tx_valid) begin
        tx_next = T_START;
        load    = 1'b1;
      end
      T_START: if (bit_end) tx_next = T_DATA;
      T_DATA:  if (bit_end && bit_idx == '0) tx_next = (PARITY_EN != 0) ? T_PAR : T_STOP;
      T_PAR:   if (bit_end) tx_next = T_STOP;
      T_STOP:  if (bit_end) tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  // txsd/txck are registered; txsd only moves at bit boundaries, where txck falls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      bit_idx  <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      txsd     <= 1'b1;
      txck     <= 1'b1;
    end else if (load) begin
      div_cnt  <= '0;
      bit_idx  <= IDX_W'(DATA_W - 1);
      tx_shreg <= tx_data;
      tx_par   <= ^tx_data;
      txsd     <= 1'b0;
      txck     <= 1'b0;
    end else if (tx_state != T_IDLE) begin
      if (bit_end) begin
        div_cnt <= '0;
        txck    <= (tx_next == T_IDLE);
        case (tx_next)
          T_DATA: begin
            if (tx_state == T_DATA) begin
              txsd     <= tx_shreg[DATA_W-2];
              tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
              bit_idx  <= bit_idx - 1'b1;
            end else begin
              txsd <= tx_shreg[DATA_W-1];
            end
          end
          T_PAR:   txsd <= tx_par;
          default: txsd <= 1'b1;
        endcase
      end else begin
        div_cnt <= div_cnt + 1'b1;
        if (div_cnt == DIV_W'(CLK_DIV - 1)) txck <= 1'b1;
      end
    end
  end

  sync_serial_rx #(
    .DATA_W   (DATA_W),
    .PARITY_EN(PARITY_EN)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .loopback_en(loopback_en),
    .txsd       (txsd),
    .txck       (txck),
    .rxsd       (rxsd),
    .rxck       (rxck),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_perr    (rx_perr),
    .rx_ferr    (rx_ferr),
    .rx_ovr     (rx_ovr)
  );

endmodule

// File: tb/tb_sync_serial_codec.sv
// tb/tb_sync_serial_codec.sv - directed self-checking bench for sync_serial_codec (DATA_W=8, CLK_DIV=4, parity on)
module tb_sync_serial_codec;
  import sync_serial_pkg::*;

  localparam int DATA_W    = 8;
  localparam int CLK_DIV   = 4;
  localparam int PARITY_EN = 1;
  localparam int FRAME_CYC = frame_nb(DATA_W, PARITY_EN) * 2 * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst_n, loopback_en, tx_valid, rx_ready, rxsd, rxck;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              tx_ready, rx_valid, rx_perr, rx_ferr, rx_ovr, txsd, txck, tx_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_serial_codec #(
    .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .PARITY_EN(PARITY_EN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .loopback_en(loopback_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_ovr(rx_ovr),
    .txsd(txsd), .txck(txck), .tx_busy(tx_busy),
    .rxsd(rxsd), .rxck(rxck)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Caller sits on a negedge; returns on the negedge after the accepting posedge.
  task automatic send_word(input logic [7:0] d);
    bit ok = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (tx_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("send_timeout", 0, 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_busy && n < 500) begin n++; @(negedge clk); end
    if (tx_busy) check(tag, 0, 1);
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    while (!rx_valid && n < 500) begin n++; @(negedge clk); end
    if (!rx_valid) check(tag, 0, 1);
  endtask

  task automatic rx_handshake();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Drives an 11-bit frame MSB first on rxsd/rxck; optionally flips loopback_en mid-frame.
  task automatic send_ext(input logic [10:0] frame, input bit lb_toggle);
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      rxck = 1'b0;
      rxsd = frame[i];
      if (lb_toggle && i == 6) loopback_en = 1'b1;
      repeat (5) @(negedge clk);
      rxck = 1'b1;
      repeat (5) @(negedge clk);
    end
    rxsd = 1'b1;
    loopback_en = 1'b0;
  endtask

  logic [7:0] got [3];
  int         gaps [2];
  int         busy_n, sent, got_n, rdy_cnt, last_hs;
  bit         pend;

  initial begin
    rst_n = 1'b0; loopback_en = 1'b0; tx_valid = 1'b0; tx_data = '0;
    rx_ready = 1'b0; rxsd = 1'b1; rxck = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txsd", txsd, 1);
    check("rst_txck", txck, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_flags", {rx_perr, rx_ferr, rx_ovr}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0xA5
    loopback_en = 1'b1;
    repeat (2) @(negedge clk);
    send_word(8'hA5);
    check("a5_ready_low", tx_ready, 0);
    check("a5_txsd_start", txsd, 0);
    busy_n = 0;
    while (tx_busy && busy_n < 300) begin busy_n++; @(negedge clk); end
    check("a5_busy_cycles", busy_n, FRAME_CYC);
    check("a5_idle_txsd_txck", {txsd, txck}, 2'b11);
    wait_rx("a5_rx_timeout");
    check("a5_rx_data", rx_data, 8'hA5);
    check("a5_flags", {rx_perr, rx_ferr, rx_ovr}, 0);
    rx_handshake();
    check("a5_valid_cleared", rx_valid, 0);

    // External 0x3C with wrong parity; loopback_en toggled mid-frame must be ignored
    loopback_en = 1'b0;
    repeat (3) @(negedge clk);
    send_ext({1'b0, 8'h3C, 1'b1, 1'b1}, 1'b1);
    wait_rx("3c_rx_timeout");
    check("3c_rx_data", rx_data, 8'h3C);
    check("3c_perr", rx_perr, 1);
    check("3c_ferr", rx_ferr, 0);
    rx_handshake();
    check("3c_cleared", {rx_valid, rx_perr}, 0);

    // External 0x81 with stop=0
    send_ext({1'b0, 8'h81, 1'b0, 1'b0}, 1'b0);
    wait_rx("81_rx_timeout");
    check("81_rx_data", rx_data, 8'h81);
    check("81_ferr", rx_ferr, 1);
    check("81_perr", rx_perr, 0);
    rx_handshake();
    check("81_cleared", {rx_valid, rx_ferr}, 0);

    // Overrun: 0x11 then 0x22 without reading
    loopback_en = 1'b1;
    repeat (3) @(negedge clk);
    send_word(8'h11);
    wait_idle("ovr_idle1_timeout");
    wait_rx("ovr_rx_timeout");
    send_word(8'h22);
    wait_idle("ovr_idle2_timeout");
    repeat (10) @(negedge clk);
    check("ovr_valid", rx_valid, 1);
    check("ovr_rx_data", rx_data, 8'h11);
    check("ovr_flag", rx_ovr, 1);
    rx_handshake();
    check("ovr_valid_cleared", rx_valid, 0);
    check("ovr_flag_cleared", rx_ovr, 0);

    // Reset in the middle of data bit 4, then 0x5A loops back intact
    send_word(8'h77);
    repeat (5 * 2 * CLK_DIV + 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_txsd_txck", {txsd, txck}, 2'b11);
    check("mrst_tx_ready", tx_ready, 1);
    check("mrst_rx_valid", rx_valid, 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("mrst_no_partial", rx_valid, 0);
    send_word(8'h5A);
    wait_idle("5a_idle_timeout");
    wait_rx("5a_rx_timeout");
    check("5a_rx_data", rx_data, 8'h5A);
    check("5a_flags", {rx_perr, rx_ferr, rx_ovr}, 0);
    rx_handshake();

    // Back-to-back 0x01, 0x02, 0x03 with tx_valid held high
    rx_ready = 1'b1;
    tx_data = 8'h01; tx_valid = 1'b1;
    sent = 0; got_n = 0; rdy_cnt = 0; last_hs = 0; pend = 0;
    for (int c = 0; c < 1500; c++) begin
      if (pend) begin
        tx_data = 8'(sent + 1);
        if (sent == 3) tx_valid = 1'b0;
        pend = 0;
      end
      if (tx_valid && tx_ready) begin
        rdy_cnt++;
        if (sent > 0) gaps[sent-1] = c - last_hs;
        last_hs = c;
        sent++;
        pend = 1;
      end
      if (rx_valid) begin
        if (got_n < 3) got[got_n] = rx_data;
        got_n++;
      end
      if (got_n >= 3 && sent >= 3 && !pend) break;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    check("b2b_sent", sent, 3);
    check("b2b_ready_cycles", rdy_cnt, 3);
    check("b2b_gap0", gaps[0], FRAME_CYC + 1);
    check("b2b_gap1", gaps[1], FRAME_CYC + 1);
    check("b2b_rx_count", got_n, 3);
    check("b2b_rx0", got[0], 8'h01);
    check("b2b_rx1", got[1], 8'h02);
    check("b2b_rx2", got[2], 8'h03);
    check("b2b_no_ovr", rx_ovr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
